// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller (consumes decode fields, drives selects/enables); slave = datapath.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic       pcen;
  logic [3:0] state;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    output alusrcb, pcsrc, alucontrol, pcen, state
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    input  alusrcb, pcsrc, alucontrol, pcen, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-FSM controller for a MIPS-style multicycle datapath with unified memory.
// Optional macro BNE_EN adds bne (op 000101) through state BNEEX.
module multicycle_ctrl (
  input  logic                    clk,
  input  logic                    reset_n,
  multicycle_ctrl_if.master       bus
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
`ifdef BNE_EN
  localparam logic [3:0] BNEEX   = 4'd12;
`endif

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q, state_d;

  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic       branchn;
  logic [1:0] aluop;
  logic [2:0] alucontrol;
  logic       take_branch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Moore decode; any select not mentioned for a state stays 0.
  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    branchn  = 1'b0;
    aluop    = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      DECODE:  alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branchn = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (bus.funct)
          6'b100000: alucontrol = ALU_ADD;
          6'b100010: alucontrol = ALU_SUB;
          6'b100100: alucontrol = ALU_AND;
          6'b100101: alucontrol = ALU_OR;
          6'b101010: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
    endcase
  end

  assign take_branch = (branch & bus.zero) | (branchn & ~bus.zero);

  // Write enables are gated by reset_n directly so an abort takes effect without a clock.
  assign bus.pcen       = reset_n & (pcwrite | take_branch);
  assign bus.irwrite    = reset_n & irwrite;
  assign bus.memwrite   = reset_n & memwrite;
  assign bus.regwrite   = reset_n & regwrite;
  assign bus.iord       = iord;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: state walks, per-state outputs, reset abort.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;
  string ins = "reset";

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s/%s: got %0h expected %0h", ins, tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and check the state reached.
  task automatic step(input logic [3:0] exp);
    @(negedge clk);
    check("state", 8'(bus.state), 8'(exp));
  endtask

  task automatic check_fetch();
    check("state", 8'(bus.state), 8'd0);
    check("irwrite", 8'(bus.irwrite), 8'd1);
    check("pcen", 8'(bus.pcen), 8'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset: FETCH selects, write enables forced low
    check("state", 8'(bus.state), 8'd0);
    check("pcen", 8'(bus.pcen), 8'd0);
    check("irwrite", 8'(bus.irwrite), 8'd0);
    check("memwrite", 8'(bus.memwrite), 8'd0);
    check("regwrite", 8'(bus.regwrite), 8'd0);
    check("alusrcb", 8'(bus.alusrcb), 8'b01);
    check("alucontrol", 8'(bus.alucontrol), 8'b010);
    check("iord", 8'(bus.iord), 8'd0);

    // lw: 0,1,2,3,4,0
    ins = "lw";
    reset_n = 1'b1;
    #1;
    check_fetch();
    check("iord", 8'(bus.iord), 8'd0);
    step(4'd1);
    check("alusrcb", 8'(bus.alusrcb), 8'b11);
    check("pcen", 8'(bus.pcen), 8'd0);
    check("irwrite", 8'(bus.irwrite), 8'd0);
    step(4'd2);
    check("alusrca", 8'(bus.alusrca), 8'd1);
    check("alusrcb", 8'(bus.alusrcb), 8'b10);
    step(4'd3);
    check("iord", 8'(bus.iord), 8'd1);
    check("regwrite", 8'(bus.regwrite), 8'd0);
    check("memtoreg", 8'(bus.memtoreg), 8'd0);
    step(4'd4);
    check("regwrite", 8'(bus.regwrite), 8'd1);
    check("memtoreg", 8'(bus.memtoreg), 8'd1);
    check("regdst", 8'(bus.regdst), 8'd0);
    check("iord", 8'(bus.iord), 8'd0);
    step(4'd0);
    check("regwrite", 8'(bus.regwrite), 8'd0);

    // sw: 0,1,2,5,0 with memwrite in state 5 only
    ins = "sw";
    bus.op = 6'b101011;
    check("memwrite", 8'(bus.memwrite), 8'd0);
    step(4'd1);
    check("memwrite", 8'(bus.memwrite), 8'd0);
    step(4'd2);
    check("memwrite", 8'(bus.memwrite), 8'd0);
    step(4'd5);
    check("memwrite", 8'(bus.memwrite), 8'd1);
    check("iord", 8'(bus.iord), 8'd1);
    check("regwrite", 8'(bus.regwrite), 8'd0);
    step(4'd0);
    check("memwrite", 8'(bus.memwrite), 8'd0);

    // R-type slt: 0,1,6,7,0
    ins = "slt";
    bus.op = 6'b000000;
    bus.funct = 6'b101010;
    step(4'd1);
    step(4'd6);
    check("alucontrol", 8'(bus.alucontrol), 8'b111);
    check("alusrca", 8'(bus.alusrca), 8'd1);
    check("alusrcb", 8'(bus.alusrcb), 8'b00);
    bus.funct = 6'b100010;
    #1 check("alu_sub", 8'(bus.alucontrol), 8'b110);
    bus.funct = 6'b100100;
    #1 check("alu_and", 8'(bus.alucontrol), 8'b000);
    bus.funct = 6'b100101;
    #1 check("alu_or", 8'(bus.alucontrol), 8'b001);
    bus.funct = 6'b111111;
    #1 check("alu_other", 8'(bus.alucontrol), 8'b010);
    bus.funct = 6'b101010;
    step(4'd7);
    check("regwrite", 8'(bus.regwrite), 8'd1);
    check("regdst", 8'(bus.regdst), 8'd1);
    check("memtoreg", 8'(bus.memtoreg), 8'd0);
    step(4'd0);

    // beq: 0,1,8,0; pcen follows zero
    ins = "beq";
    bus.op = 6'b000100;
    bus.zero = 1'b1;
    step(4'd1);
    check("pcen", 8'(bus.pcen), 8'd0);
    step(4'd8);
    check("pcen", 8'(bus.pcen), 8'd1);
    check("pcsrc", 8'(bus.pcsrc), 8'b01);
    check("alucontrol", 8'(bus.alucontrol), 8'b110);
    bus.zero = 1'b0;
    #1 check("pcen_nz", 8'(bus.pcen), 8'd0);
    step(4'd0);

    // addi: 0,1,9,10,0
    ins = "addi";
    bus.op = 6'b001000;
    step(4'd1);
    step(4'd9);
    check("alusrcb", 8'(bus.alusrcb), 8'b10);
    check("alucontrol", 8'(bus.alucontrol), 8'b010);
    step(4'd10);
    check("regwrite", 8'(bus.regwrite), 8'd1);
    check("memtoreg", 8'(bus.memtoreg), 8'd0);
    check("regdst", 8'(bus.regdst), 8'd0);
    step(4'd0);

    // j: 0,1,11,0
    ins = "j";
    bus.op = 6'b000010;
    step(4'd1);
    step(4'd11);
    check("pcsrc", 8'(bus.pcsrc), 8'b10);
    check("pcen", 8'(bus.pcen), 8'd1);
    step(4'd0);

    // unknown op: 0,1,0, no write enables
    ins = "unknown";
    bus.op = 6'b111111;
    step(4'd1);
    check("wr_en", 8'({bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen}), 8'd0);
    step(4'd0);

    // bne
    ins = "bne";
    bus.op = 6'b000101;
    bus.zero = 1'b0;
    step(4'd1);
`ifdef BNE_EN
    step(4'd12);
    check("pcen", 8'(bus.pcen), 8'd1);
    check("pcsrc", 8'(bus.pcsrc), 8'b01);
    bus.zero = 1'b1;
    #1 check("pcen_z", 8'(bus.pcen), 8'd0);
    bus.zero = 1'b0;
`else
    check("wr_en", 8'({bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen}), 8'd0);
`endif
    step(4'd0);

    // Reset abort in MEMRD of lw
    ins = "lw_abort";
    bus.op = 6'b100011;
    step(4'd1);
    step(4'd2);
    step(4'd3);
    reset_n = 1'b0;
    #1;
    check("state", 8'(bus.state), 8'd0);
    check("wr_en", 8'({bus.regwrite, bus.memwrite, bus.irwrite, bus.pcen}), 8'd0);
    check("iord", 8'(bus.iord), 8'd0);
    @(negedge clk);
    check("state_held", 8'(bus.state), 8'd0);
    check("regwrite", 8'(bus.regwrite), 8'd0);
    reset_n = 1'b1;
    #1;
    check_fetch();
    step(4'd1);
    step(4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed by this document.
REQ-002 clk  in  1  rising-edge clock, the same clock as the unified instruction/data memory.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 op  in  6  instruction[31:26], from the instruction register.
REQ-005 funct  in  6  instruction[5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 memwrite  out  1  drives the memory's we port.
REQ-009 irwrite  out  1  instruction register load enable.
REQ-010 regdst, memtoreg, regwrite, alusrca  out  1 each  standard datapath selects and enable.
REQ-011 alusrcb  out  2  ALU B input select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-012 pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-013 alucontrol  out  3  ALU operation code.
REQ-014 pcen  out  1  PC register enable.
REQ-015 state  out  4  current state, for debug.

Function
REQ-016 The controller SHALL be a Moore FSM with these encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
REQ-017 Transitions: FETCH->DECODE. DECODE goes to MEMADR (lw 100011 or sw 101011), RTYPEEX (000000), BEQEX (beq 000100), ADDIEX (001000) or JEX (000010). MEMADR goes to MEMRD for lw, MEMWR for sw. MEMRD->MEMWB. RTYPEEX->RTYPEWB. ADDIEX->ADDIWB. MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX each go to FETCH.
REQ-018 An unknown op in DECODE SHALL return the FSM to FETCH with no write enable asserted.
REQ-019 FETCH outputs: iord=0, irwrite=1, alusrca=0, alusrcb=01, ALU add, pcsrc=00, pcwrite=1.
REQ-020 DECODE outputs: alusrca=0, alusrcb=11, ALU add.
REQ-021 MEMADR outputs: alusrca=1, alusrcb=10, ALU add.
REQ-022 MEMRD: iord=1. MEMWB: regdst=0, memtoreg=1, regwrite=1. MEMWR: iord=1, memwrite=1.
REQ-023 RTYPEEX: alusrca=1, alusrcb=00, ALU operation from funct. RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-024 BEQEX: alusrca=1, alusrcb=00, ALU sub, pcsrc=01, branch=1.
REQ-025 ADDIEX: alusrca=1, alusrcb=10, ALU add. ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-026 JEX: pcsrc=10, pcwrite=1.
REQ-027 Any output not listed for a state SHALL be 0.
REQ-028 alucontrol SHALL be: add=010, sub=110; for R-type, funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, and any other funct->010.
REQ-029 pcen SHALL equal pcwrite OR (branch AND zero), combinationally.
REQ-030 memwrite SHALL be high for exactly one clk cycle per sw; memory latches on the edge that leaves MEMWR.
REQ-031 Read data SHALL be sampled by the datapath on the edge that leaves MEMRD (memory read is combinational).
REQ-032 Cycle counts per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.

Reset
REQ-033 While reset_n=0, state SHALL be FETCH asynchronously.
REQ-034 While reset_n=0, pcen, irwrite, memwrite and regwrite SHALL be forced to 0.
REQ-035 All other outputs during reset SHALL take their FETCH values.
REQ-036 Reset asserted mid-instruction SHALL abort it with no further memory or register write.
REQ-037 The first rising edge after reset_n rises SHALL perform a normal FETCH.

Configuration
REQ-038 Macro BNE_EN, when defined, SHALL add op 000101: DECODE->BNEEX (state 12), with BEQEX outputs except pcen = pcwrite OR (branchn AND NOT zero); BNEEX->FETCH.
REQ-039 Without BNE_EN, op 000101 SHALL be treated as an unknown opcode (REQ-018).

Verification
REQ-040 Release reset, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
REQ-041 op=101011 -> states 0,1,2,5,0; memwrite=1 for exactly one cycle, in state 5.
REQ-042 op=000000, funct=101010 -> alucontrol=111 in state 6; regwrite=1 and regdst=1 in state 7.
REQ-043 op=000100 with zero=1 -> pcen=1 in state 8; with zero=0 -> pcen=0.
REQ-044 Drop reset_n in state 3 (lw) -> state=0 immediately, no regwrite; op=111111 -> states 0,1,0 with all write enables 0.
REQ-045 With BNE_EN, op=000101, zero=0 -> state 12 and pcen=1; without BNE_EN -> states 0,1,0.
